// File: rtl/digct_monitor.sv
// digct_monitor: debounces the three DigCt flags, counts debounced rising edges in
// saturating counters, and serves a four-phase clear-on-read port for them.
module digct_monitor #(
    parameter int DEB_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flag1_i,
    input  logic             flag2_i,
    input  logic             flag3_i,
    input  logic             rd_req_i,
    input  logic [1:0]       rd_sel_i,
    output logic             rd_ack_o,
    output logic [CNT_W-1:0] rd_data_o,
    output logic [2:0]       deb_out_o,
    output logic             any_evt_o
);
    typedef enum logic {IDLE, ACK} state_e;

    localparam logic [3:0]       LIM  = 4'(DEB_CYC);
    localparam logic [CNT_W-1:0] CMAX = '1;

    state_e                  state_q, state_d;
    logic [2:0][3:0]         stab_q, stab_d;
    logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]              deb_q, deb_d, prev_q, rise, flag;
    logic [CNT_W-1:0]        rd_data_q, rd_data_d;
    logic                    any_q, accept;

    assign flag   = {flag3_i, flag2_i, flag1_i};
    assign rise   = deb_q & ~prev_q;
    assign accept = state_q == IDLE && rd_req_i;

    always_comb begin
        stab_d = stab_q;
        deb_d  = deb_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 3; i++) begin
            stab_d[i] = (flag[i] == deb_q[i] || stab_q[i] + 4'd1 == LIM) ? 4'd0 : stab_q[i] + 4'd1;
            deb_d[i]  = (flag[i] != deb_q[i] && stab_q[i] + 4'd1 == LIM) ? flag[i] : deb_q[i];
            // a clear coinciding with an event keeps that event
            cnt_d[i]  = (accept && rd_sel_i == 2'(i)) ? CNT_W'(rise[i]) :
                        (rise[i] && cnt_q[i] != CMAX) ? cnt_q[i] + 1'b1 : cnt_q[i];
        end
        state_d   = accept ? ACK : (state_q == ACK && !rd_req_i) ? IDLE : state_q;
        rd_data_d = !accept           ? rd_data_q :
                    rd_sel_i == 2'd0  ? cnt_q[0]  :
                    rd_sel_i == 2'd1  ? cnt_q[1]  :
                    rd_sel_i == 2'd2  ? cnt_q[2]  : CNT_W'(deb_q);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            stab_q    <= '0;
            cnt_q     <= '0;
            deb_q     <= '0;
            prev_q    <= '0;
            rd_data_q <= '0;
            any_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            prev_q    <= deb_q;
            rd_data_q <= rd_data_d;
            any_q     <= |rise;
        end
    end

    assign rd_ack_o  = state_q == ACK;
    assign rd_data_o = rd_data_q;
    assign deb_out_o = deb_q;
    assign any_evt_o = any_q;
endmodule

// File: tb/tb_digct_monitor.sv
// tb_digct_monitor: directed and random stimulus; read responses are predicted by a
// behavioural model into a queue and checked by an independent monitor.
module tb_digct_monitor;
    localparam int DEB_CYC = 4;
    localparam int CNT_W   = 8;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic             clk = 1'b0, rst_n = 1'b1;
    logic             flag1 = 1'b0, flag2 = 1'b0, flag3 = 1'b0, rd_req = 1'b0;
    logic [1:0]       rd_sel = 2'd0;
    logic             rd_ack, any_evt;
    logic [CNT_W-1:0] rd_data;
    logic [2:0]       deb_out;

    int cmp = 0, errs = 0, evt_n = 0;

    digct_monitor #(.DEB_CYC(DEB_CYC), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flag1_i(flag1), .flag2_i(flag2), .flag3_i(flag3),
        .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_ack_o(rd_ack), .rd_data_o(rd_data),
        .deb_out_o(deb_out), .any_evt_o(any_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: flags become debounced once they differ for DEB_CYC samples in a row;
    // each debounced rise adds one saturating event on the following edge.
    int       m_run[3];
    int       m_cnt[3];
    bit [2:0] m_deb, m_rise;
    bit       m_ack, m_evt;
    int       exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        bit [2:0] f, old;
        bit acc;
        if (!rst_n) begin
            m_run = '{0, 0, 0}; m_cnt = '{0, 0, 0};
            m_deb = 0; m_rise = 0; m_ack = 0; m_evt = 0;
            exp_q.delete();
        end else begin
            f   = {flag3, flag2, flag1};
            acc = !m_ack && rd_req;
            if (acc) exp_q.push_back(rd_sel == 2'd3 ? int'(m_deb) : m_cnt[rd_sel]);
            for (int c = 0; c < 3; c++) begin
                if (acc && rd_sel == 2'(c)) m_cnt[c] = m_rise[c] ? 1 : 0;
                else if (m_rise[c] && m_cnt[c] < MAXC) m_cnt[c]++;
            end
            m_evt = |m_rise;
            if (acc) m_ack = 1;
            else if (m_ack && !rd_req) m_ack = 0;
            old = m_deb;
            for (int c = 0; c < 3; c++) begin
                m_run[c] = (f[c] == m_deb[c]) ? 0 : m_run[c] + 1;
                if (m_run[c] == DEB_CYC) begin
                    m_deb[c] = f[c];
                    m_run[c] = 0;
                end
            end
            m_rise = m_deb & ~old;
        end
    end

    // Monitor: per-cycle output check plus scoreboard pop on each new acknowledge.
    bit ack_prev = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("deb_out", deb_out, m_deb);
            chk("any_evt", any_evt, m_evt);
            chk("rd_ack", rd_ack, m_ack);
            if (any_evt) evt_n++;
            if (rd_ack && !ack_prev) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
                else chk("rd_data_sb", rd_data, exp_q.pop_front());
            end
            ack_prev = rd_ack;
        end else ack_prev = 0;
    end

    task automatic hold(input bit [2:0] f, input int n);
        {flag3, flag2, flag1} = f;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_read(input bit [1:0] sel, input int exp);
        int t;
        rd_sel = sel;
        rd_req = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!rd_ack && t < 20);
        if (!rd_ack) chk("ack_timeout", 0, 1);
        else if (exp >= 0) chk($sformatf("read_sel%0d", sel), rd_data, exp);
        rd_req = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (rd_ack && t < 20);
        if (rd_ack) chk("ack_release_timeout", 1, 0);
    endtask

    initial begin
        #3 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            {flag3, flag2, flag1} = 3'($urandom);
            rd_req = 1'($urandom);
            rd_sel = 2'($urandom);
            #1 chk("reset_outs", {rd_ack, rd_data, deb_out, any_evt}, 0);
        end
        @(negedge clk);
        {flag3, flag2, flag1} = 3'b000;
        rd_req = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_outs", {rd_ack, rd_data, deb_out, any_evt}, 0);

        hold(3'b001, 3);
        hold(3'b000, 8);
        chk("glitch_deb", deb_out, 0);
        chk("glitch_evt", evt_n, 0);
        hold(3'b001, 4);
        chk("deb_rise_4th_edge", deb_out, 1);
        hold(3'b000, 1);
        chk("evt_pulse", any_evt, 1);
        hold(3'b000, 8);

        repeat (5) begin hold(3'b010, 5); hold(3'b000, 5); end
        do_read(2'd1, 5);
        do_read(2'd1, 0);

        repeat (300) begin hold(3'b100, 4); hold(3'b000, 4); end
        do_read(2'd2, MAXC);

        do_read(2'd0, 1);
        repeat (7) begin hold(3'b001, 5); hold(3'b000, 5); end
        hold(3'b001, 4);
        do_read(2'd0, 7);
        hold(3'b001, 2);
        hold(3'b000, 6);
        do_read(2'd0, 1);

        hold(3'b101, 6);
        rd_sel = 2'd3;
        rd_req = 1'b1;
        @(negedge clk);
        chk("deb_vec_ack", rd_ack, 1);
        chk("deb_vec_data", rd_data, 5);
        repeat (5) begin @(negedge clk); chk("ack_held", rd_ack, 1); end
        #2 rst_n = 1'b0;
        #1 chk("ack_async_drop", rd_ack, 0);
        chk("deb_async_clr", deb_out, 0);
        @(negedge clk);
        {flag3, flag2, flag1} = 3'b000;
        rd_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        do_read(2'd3, 0);
        do_read(2'd0, 0);

        repeat (300) begin
            hold(3'($urandom), $urandom_range(1, 8));
            if ($urandom_range(0, 3) == 0) do_read(2'($urandom_range(0, 3)), -1);
        end
        hold(3'b000, 10);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", cmp);
        $fatal(1);
    end
endmodule

// File: doc/digct_monitor.md
# digct_monitor

Downstream consumer of the three registered flags produced by the DigCt flag stage. The block debounces each flag and counts debounced rising edges in per-channel saturating counters. A four-phase request/acknowledge port reads a selected counter with clear-on-read. It sits between the DigCt flag outputs and the status/readout logic, and turns raw flag toggling into stable event statistics.

## Interface
- DEB_CYC, default 4: consecutive differing samples required before a debounced flag changes; legal range 1..15.
- CNT_W, default 8: event counter width; counters saturate at 2^CNT_W-1.

- CLK  input  1  single clock; all state updates on its rising edge.
- RST_N  input  1  reset, asynchronous and active-low; asserted low clears all state immediately.
- FLAG1, FLAG2, FLAG3  input  1 each  flags from the DigCt stage, already registered on CLK, used without synchronizers.
- RD_REQ  input  1  read request, level, four-phase.
- RD_SEL  input  2  channel select: 0/1/2 selects counter of FLAG1/2/3; 3 selects the debounced flag vector.
- RD_ACK  output  1  read acknowledge, registered.
- RD_DATA  output  CNT_W  read data, registered, held until the next accepted read.
- DEB_OUT  output  3  debounced flags, bit i = FLAGi+1.
- ANY_EVT  output  1  one-cycle pulse on any debounced rising edge.

## Operation
- Reset values: DEB_OUT=0, all debounce counts=0, event counters=0, RD_ACK=0, RD_DATA=0, ANY_EVT=0, FSM=IDLE.
- Debounce, per channel:
  - If the sampled flag equals DEB_OUT[i], the stability count clears to 0.
  - Otherwise the count increments.
  - When the count would reach DEB_CYC, DEB_OUT[i] takes the flag value and the count clears.
  - A glitch shorter than DEB_CYC cycles never changes DEB_OUT.
- Event detection: a rising edge is DEB_OUT[i] going 0->1. On that edge the counter increments, unless it is at max, where it holds. ANY_EVT is high for the one cycle after any channel's rising edge. Falling edges are not counted.
- Read FSM, two states:
  - IDLE: RD_ACK=0. When RD_REQ=1 is sampled:
    - RD_SEL 0..2: RD_DATA is loaded with the selected counter, and that counter is cleared.
    - RD_SEL=3: RD_DATA is loaded with {0..., DEB_OUT}, and nothing is cleared.
    - RD_ACK is set to 1 and the FSM goes to ACK.
  - ACK: RD_ACK=1, and RD_SEL is ignored. When RD_REQ=0 is sampled, RD_ACK is set to 0 and the FSM goes to IDLE.
- Simultaneous clear and increment on the same channel in the same cycle: RD_DATA gets the pre-increment value and the counter becomes 1. No event is lost.
- Reset asserted mid-handshake: RD_ACK drops asynchronously, the FSM returns to IDLE, and the counters clear. The requester must restart the read.

## Timing
- Flag change to DEB_OUT: DEB_CYC cycles. A flag changing before edge k and staying stable updates DEB_OUT at edge k+DEB_CYC-1.
- DEB_OUT rise to counter increment and ANY_EVT: 1 cycle.
- RD_REQ sampled high at edge k: RD_ACK and RD_DATA are valid after edge k.
- RD_REQ sampled low at edge m (FSM in ACK): RD_ACK goes low after edge m.
- Minimum full read cycle: 2 clocks. A new request is not accepted until the FSM has returned to IDLE.
- RD_DATA and DEB_OUT are stable between edges; there are no combinational paths from inputs to outputs.

## Test plan
Defaults: DEB_CYC=4, CNT_W=8.
- Reset: with RST_N low and random inputs, all outputs are 0. Release RST_N, hold all flags at 0 for 10 cycles -> outputs stay 0.
- Glitch filter: FLAG1 high for 3 cycles, then low -> DEB_OUT stays 000 and ANY_EVT never pulses. FLAG1 high for 4 cycles -> DEB_OUT[0]=1 at the 4th edge, ANY_EVT pulse 1 cycle later.
- Counting and read: 5 clean pulses on FLAG2, then a read with RD_SEL=1 -> RD_DATA=5 with RD_ACK=1. A second read with RD_SEL=1 -> RD_DATA=0.
- Saturation: 300 clean pulses on FLAG3, then a read with RD_SEL=2 -> RD_DATA=255.
- Clear/increment collision: time the FLAG1 debounced rise so its increment coincides with an accepted read of counter 0 holding 7 -> RD_DATA=7. Next read -> 1.
- Handshake and reset: with RD_SEL=3 and DEB_OUT=101, read -> RD_DATA=0x05. Keep RD_REQ high 5 cycles -> RD_ACK stays 1. Assert RST_N low in the ACK state -> RD_ACK=0 immediately, and the FSM accepts a fresh request after release.
